stream_latency_0_to_n: RTL
==========================

STREAM_LATENCY_0_TO_N -- requirements
Module: stream_latency_0_to_n

Interface
REQ-001 SHALL have parameter BITS, default 8: data width.
REQ-002 SHALL have parameter LATENCY, default 1: downstream ready latency; legal range 1..4.
REQ-003 SHALL have parameter DEPTH, default 4: buffer entries; power of two, >= 2.
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port srst_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port din, input, BITS bits: upstream data.
REQ-008 SHALL have ports din_sop / din_eop, input, 1 bit each: upstream packet start / end markers.
REQ-009 SHALL have port din_val, input, 1 bit: upstream valid.
REQ-010 SHALL have port din_rdy, output, 1 bit: upstream ready, latency 0.
REQ-011 SHALL have port dout, output, BITS bits: downstream data.
REQ-012 SHALL have ports dout_sop / dout_eop, output, 1 bit each: downstream markers.
REQ-013 SHALL have port dout_val, output, 1 bit: downstream valid.
REQ-014 SHALL have port dout_rdy, input, 1 bit: downstream ready, latency LATENCY.
REQ-015 SHALL have port level, output, $clog2(DEPTH)+1 bits: current buffer occupancy.

Function
REQ-016 SHALL accept an upstream beat only when din_val=1 and din_rdy=1 in the same cycle; din, din_sop and din_eop are ignored otherwise.
REQ-017 SHALL drive din_rdy = (level < DEPTH) and srst_n=1, from registered state only; there is no same-cycle push-while-full even if a pop occurs.
REQ-018 SHALL store {din_sop, din_eop, din} of each accepted beat in a DEPTH-entry circular FIFO; pointers wrap modulo DEPTH.
REQ-019 SHALL delay dout_rdy through a LATENCY-stage register chain; the output of the last stage is "slot".
REQ-020 SHALL drive dout_val = slot and (level > 0); dout_val is never 1 unless dout_rdy was 1 exactly LATENCY cycles earlier.
REQ-021 SHALL pop the head entry in every cycle where dout_val=1; downstream has no means to refuse a beat.
REQ-022 SHALL drive dout, dout_sop and dout_eop from the head entry at all times; values are don't-care but stable while dout_val=0.
REQ-023 SHALL NOT bypass: a beat accepted in cycle t appears on dout no earlier than cycle t+1.
REQ-024 SHALL leave level unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-025 SHALL treat slot=1 with level=0 as a bubble: dout_val=0 and that slot is lost, not carried forward.
REQ-026 SHALL sustain one beat per cycle when dout_rdy is held at 1 and din_val is held at 1.
REQ-027 SHALL preserve beat order and sop/eop bits exactly; no packet awareness is required.

Reset
REQ-028 SHALL, in any cycle with srst_n=0, clear level, both pointers and the dout_rdy delay chain on the next edge.
REQ-029 SHALL drive din_rdy=0 and dout_val=0 during that cycle, so reset mid-packet discards all buffered beats.
REQ-030 SHALL present level=0, din_rdy=1 and dout_val=0 in the first cycle after release.
REQ-031 SHALL NOT assert dout_val until a dout_rdy sampled after release has traversed the chain (>= LATENCY cycles).
REQ-032 Stored data SHALL need no reset.

Verification
REQ-033 Streaming (LATENCY=1, DEPTH=4): din_val=1 and dout_rdy=1 always; beats 0x01..0x10 -> dout_val=1 every cycle from the 2nd beat on, data in order, level <= 1.
REQ-034 Fill/full: dout_rdy=0, push 6 beats -> din_rdy=0 after the 4th beat, level=4; raise dout_rdy at cycle T -> first dout_val at T+1 (data 1st beat), din_rdy=1 at T+2.
REQ-035 Latency honour (LATENCY=3): buffer holds 2 beats, dout_rdy pulsed high for 1 cycle at T -> exactly one dout_val at T+3, level 2->1.
REQ-036 Bubble: level=0, dout_rdy=1 at T, first push at T+1 -> dout_val=0 at T+1, beat appears at T+2.
REQ-037 Reset mid-packet: 3 beats buffered (sop on 1st), srst_n=0 for 1 cycle -> level=0, dout_val=0 until dout_rdy is re-sampled; the next packet's sop beat is the first beat out.
REQ-038 Random: random din_val and dout_rdy over 10k cycles, DEPTH=2 and 8, LATENCY=1..4 -> scoreboard matches, no dout_val without dout_rdy LATENCY cycles earlier, level never > DEPTH.

Source files
------------

// File: rtl/stream_latency_0_to_n.sv
// Stream buffer bridging a zero-latency ready upstream to a downstream whose
// ready takes effect LATENCY cycles later; a small circular FIFO absorbs the gap.
module stream_latency_0_to_n #(
    parameter int BITS    = 8,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     srst_n,
    input  logic [BITS-1:0]          din,
    input  logic                     din_sop,
    input  logic                     din_eop,
    input  logic                     din_val,
    output logic                     din_rdy,
    output logic [BITS-1:0]          dout,
    output logic                     dout_sop,
    output logic                     dout_eop,
    output logic                     dout_val,
    input  logic                     dout_rdy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = BITS + 2;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [EW-1:0]      mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic [LATENCY-1:0] chain_r;
    logic [LATENCY:0]   shift_s;
    logic               slot_s;
    logic               push_s;
    logic               pop_s;

    // Handshake decode; all of it derives from registered state plus reset.
    always_comb begin
        shift_s  = {chain_r, dout_rdy};
        slot_s   = chain_r[LATENCY-1];
        din_rdy  = srst_n && (level_r < DEPTH_L);
        dout_val = srst_n && slot_s && (level_r != {LW{1'b0}});
        push_s   = din_val && din_rdy;
        pop_s    = dout_val;
        {dout_sop, dout_eop, dout} = mem_r[rd_ptr_r];
        level    = level_r;
    end

    // Downstream ready delay chain; a slot unused by an empty buffer is dropped.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            chain_r <= {LATENCY{1'b0}};
        end else begin
            chain_r <= shift_s[LATENCY-1:0];
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Payload storage; contents are qualified by level, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {din_sop, din_eop, din};
        end
    end

endmodule
